// File: rtl/ram_arb_pkg.sv
// ============================================================================
// Module : ram_arb_pkg
// Brief  : Shared state encodings and port identifiers for ram_port_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arb_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef logic port_id_t;

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// ============================================================================
// Module : rr_grant2
// Brief  : Two-way round-robin picker; Ptr names the port that wins a tie.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_grant2
    import ram_arb_pkg::*;
(
    input  logic       Req0,
    input  logic       Req1,
    input  logic       Ptr,
    output logic [1:0] Win
);

    always_comb begin
        Win = 2'b00;
        if (Req0 && Req1) begin
            Win = (Ptr == PORT1) ? 2'b10 : 2'b01;
        end else if (Req0) begin
            Win = 2'b01;
        end else if (Req1) begin
            Win = 2'b10;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ============================================================================
// Module : ram_port_arbiter
// Brief  : Round-robin sharing of one registered-read single-port RAM
//          between two requesters, one transaction in flight at a time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int MEM_WIDTH  = 16
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  Wr0,
    input  logic                  Wr1,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [MEM_WIDTH-1:0]  WData0,
    input  logic [MEM_WIDTH-1:0]  WData1,
    output logic                  Gnt0,
    output logic                  Gnt1,
    output logic                  RValid0,
    output logic                  RValid1,
    output logic [MEM_WIDTH-1:0]  RData0,
    output logic [MEM_WIDTH-1:0]  RData1,
    output logic                  Busy,
    output logic                  RamWrEn,
    output logic                  RamRdEn,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic [MEM_WIDTH-1:0]  RamWrData,
    input  logic [MEM_WIDTH-1:0]  RamRdData
);

    logic [1:0]            r_state;
    port_id_t              r_ptr;
    port_id_t              r_owner;
    logic [1:0]            w_win;
    port_id_t              w_sel;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [MEM_WIDTH-1:0]  w_wdata;

    rr_grant2 u_rr_grant2 (
        .Req0 (Req0),
        .Req1 (Req1),
        .Ptr  (r_ptr),
        .Win  (w_win)
    );

    assign w_sel   = w_win[1];
    assign w_wr    = (w_sel == PORT1) ? Wr1    : Wr0;
    assign w_addr  = (w_sel == PORT1) ? Addr1  : Addr0;
    assign w_wdata = (w_sel == PORT1) ? WData1 : WData0;

    // Pulses and RAM command default low every cycle; only the IDLE grant
    // path raises the command, so it is held for exactly the ISSUE cycle.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PORT0;
            r_owner    <= PORT0;
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            RValid0    <= 1'b0;
            RValid1    <= 1'b0;
            RData0     <= '0;
            RData1     <= '0;
            Busy       <= 1'b0;
            RamWrEn    <= 1'b0;
            RamRdEn    <= 1'b0;
            RamAddress <= '0;
            RamWrData  <= '0;
        end else begin
            Gnt0       <= 1'b0;
            Gnt1       <= 1'b0;
            RValid0    <= 1'b0;
            RValid1    <= 1'b0;
            RamWrEn    <= 1'b0;
            RamRdEn    <= 1'b0;
            RamAddress <= '0;
            RamWrData  <= '0;
            case (r_state)
                ST_IDLE: begin
                    Busy <= 1'b0;
                    if (Req0 || Req1) begin
                        r_owner    <= w_sel;
                        r_ptr      <= ~w_sel;
                        Gnt0       <= w_win[0];
                        Gnt1       <= w_win[1];
                        RamWrEn    <= w_wr;
                        RamRdEn    <= ~w_wr;
                        RamAddress <= w_addr;
                        RamWrData  <= w_wr ? w_wdata : '0;
                        Busy       <= 1'b1;
                        r_state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    Busy    <= RamRdEn;
                    r_state <= RamRdEn ? ST_RESP : ST_IDLE;
                end
                ST_RESP: begin
                    if (r_owner == PORT1) begin
                        RData1  <= RamRdData;
                        RValid1 <= 1'b1;
                    end else begin
                        RData0  <= RamRdData;
                        RValid0 <= 1'b1;
                    end
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    Busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
// ============================================================================
// Module : tb_ram_port_arbiter
// Brief  : Self-checking bench: directed scenarios plus random two-port traffic
//          against a transaction-schedule reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int MAXC = 2048;

    typedef struct {
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } txn_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b0;
    logic          Req0 = 1'b0, Req1 = 1'b0, Wr0 = 1'b0, Wr1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic          Gnt0, Gnt1, RValid0, RValid1, Busy, RamWrEn, RamRdEn;
    logic [DW-1:0] RData0, RData1, RamWrData;
    logic [AW-1:0] RamAddress;
    logic [DW-1:0] RamRdData;

    always #5 Clk = ~Clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .MEM_WIDTH(DW)) dut (
        .Clk(Clk), .Rst(Rst),
        .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RData0(RData0), .RData1(RData1), .Busy(Busy),
        .RamWrEn(RamWrEn), .RamRdEn(RamRdEn), .RamAddress(RamAddress),
        .RamWrData(RamWrData), .RamRdData(RamRdData)
    );

    // Behavioural single-port RAM: registered read, write wins over read.
    logic [DW-1:0] ram [16];
    logic          clr = 1'b1;
    always @(posedge Clk) begin
        if (clr) begin
            for (int i = 0; i < 16; i++) ram[i] <= '0;
            RamRdData <= '0;
        end else if (RamWrEn) begin
            ram[RamAddress] <= RamWrData;
        end else if (RamRdEn) begin
            RamRdData <= ram[RamAddress];
        end
    end

    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Reference model: expected outputs scheduled per clock edge index.
    bit            e_g0 [MAXC], e_g1 [MAXC], e_rv0 [MAXC], e_rv1 [MAXC];
    bit            e_we [MAXC], e_re [MAXC], e_busy [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_wd [MAXC], e_rval [MAXC];
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] exp_rd0, exp_rd1;
    int            free_at = 0;
    int            prefer  = 0;
    txn_t          q0 [$], q1 [$];
    int            glog [$];
    int            cnt_re, cnt_rv0, cnt_rv1, cnt_g1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic clear_slot(int k);
        if (k < MAXC) begin
            e_g0[k] = 0; e_g1[k] = 0; e_rv0[k] = 0; e_rv1[k] = 0;
            e_we[k] = 0; e_re[k] = 0; e_busy[k] = 0;
            e_addr[k] = '0; e_wd[k] = '0; e_rval[k] = '0;
        end
    endtask

    task automatic model_edge(int k);
        int   w;
        txn_t t;
        if (!Rst) begin
            for (int j = k; j < k + 4; j++) clear_slot(j);
            free_at = k + 1;
            prefer  = 0;
            exp_rd0 = '0;
            exp_rd1 = '0;
        end else begin
            if (e_rv0[k]) exp_rd0 = e_rval[k];
            if (e_rv1[k]) exp_rd1 = e_rval[k];
            if (k >= free_at && (Req0 || Req1)) begin
                w = (Req0 && Req1) ? prefer : (Req1 ? 1 : 0);
                prefer = 1 - w;
                t.wr = (w == 1) ? Wr1 : Wr0;
                t.a  = (w == 1) ? Addr1 : Addr0;
                t.d  = (w == 1) ? WData1 : WData0;
                if (w == 1) e_g1[k] = 1; else e_g0[k] = 1;
                e_busy[k] = 1;
                e_addr[k] = t.a;
                if (t.wr) begin
                    e_we[k]     = 1;
                    e_wd[k]     = t.d;
                    ref_mem[t.a] = t.d;
                    free_at     = k + 2;
                end else begin
                    e_re[k]       = 1;
                    e_busy[k + 1] = 1;
                    e_rval[k + 2] = ref_mem[t.a];
                    if (w == 1) e_rv1[k + 2] = 1; else e_rv0[k + 2] = 1;
                    free_at       = k + 3;
                end
            end
        end
    endtask

    task automatic drive();
        Req0 = (q0.size() != 0);
        Req1 = (q1.size() != 0);
        if (Req0) begin Wr0 = q0[0].wr; Addr0 = q0[0].a; WData0 = q0[0].d; end
        else begin Wr0 = 1'b0; Addr0 = '0; WData0 = '0; end
        if (Req1) begin Wr1 = q1[0].wr; Addr1 = q1[0].a; WData1 = q1[0].d; end
        else begin Wr1 = 1'b0; Addr1 = '0; WData1 = '0; end
    endtask

    task automatic tick();
        drive();
        @(posedge Clk);
        n++;
        model_edge(n);
        #1;
        chk("gnt0", Gnt0, e_g0[n]);
        chk("gnt1", Gnt1, e_g1[n]);
        chk("rvalid0", RValid0, e_rv0[n]);
        chk("rvalid1", RValid1, e_rv1[n]);
        chk("busy", Busy, e_busy[n]);
        chk("ram_wren", RamWrEn, e_we[n]);
        chk("ram_rden", RamRdEn, e_re[n]);
        chk("ram_addr", RamAddress, e_addr[n]);
        if (e_we[n] || !e_re[n]) chk("ram_wrdata", RamWrData, e_wd[n]);
        chk("rdata0", RData0, exp_rd0);
        chk("rdata1", RData1, exp_rd1);
        chk("en_exclusive", RamWrEn & RamRdEn, 0);
        chk("gnt_exclusive", Gnt0 & Gnt1, 0);
        if (Gnt0) glog.push_back(0);
        if (Gnt1) glog.push_back(1);
        if (RamRdEn) cnt_re++;
        if (RValid0) cnt_rv0++;
        if (RValid1) cnt_rv1++;
        if (Gnt1) cnt_g1++;
        if (e_g0[n]) void'(q0.pop_front());
        if (e_g1[n]) void'(q1.pop_front());
    endtask

    task automatic drain(int limit);
        int k;
        k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || n < free_at) && k < limit) begin
            tick();
            k++;
        end
        chk("drain_timeout", (k < limit), 1);
        tick();
    endtask

    task automatic do_reset(int cycles);
        Rst = 1'b0;
        #1;
        chk("async_rst_busy", Busy, 0);
        chk("async_rst_gnt", {Gnt0, Gnt1, RValid0, RValid1}, 0);
        chk("async_rst_ram", {RamWrEn, RamRdEn, RamAddress}, 0);
        for (int i = 0; i < cycles; i++) tick();
        Rst = 1'b1;
    endtask

    function automatic txn_t mk(bit wr, int a, int d);
        txn_t t;
        t.wr = wr;
        t.a  = AW'(a);
        t.d  = DW'(d);
        return t;
    endfunction

    initial begin
        int exp3 [4];
        int k;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < MAXC; i++) clear_slot(i);
        exp_rd0 = '0;
        exp_rd1 = '0;

        // 1: reset held with a pending port-0 request
        q0.push_back(mk(1, 5, 16'h1234));
        for (int i = 0; i < 3; i++) tick();
        chk("t1_rst_rdata", {RData0, RData1}, 0);
        Rst = 1'b1;
        clr = 1'b0;
        tick();
        chk("t1_gnt0_after_release", Gnt0, 1);
        drain(20);

        // 2: port-0 write then read back
        cnt_rv0 = 0; cnt_rv1 = 0;
        q0.push_back(mk(1, 3, 16'hBEEF));
        q0.push_back(mk(0, 3, 0));
        drain(20);
        chk("t2_rdata0", RData0, 16'hBEEF);
        chk("t2_rvalid0_count", cnt_rv0, 1);
        chk("t2_rvalid1_count", cnt_rv1, 0);

        // 3: both ports contend for reads after reset
        do_reset(1);
        glog.delete();
        cnt_rv0 = 0; cnt_rv1 = 0;
        for (int i = 0; i < 2; i++) begin
            q0.push_back(mk(0, 3, 0));
            q1.push_back(mk(0, 5, 0));
        end
        drain(40);
        exp3 = '{0, 1, 0, 1};
        chk("t3_grant_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) chk("t3_grant_order", glog[i], exp3[i]);
        chk("t3_rvalid_ports", {cnt_rv0[3:0], cnt_rv1[3:0]}, 8'h22);

        // 4: back-to-back writes on port 1 only
        cnt_re = 0; cnt_g1 = 0;
        for (int i = 0; i < 3; i++) q1.push_back(mk(1, 8 + i, 16'hA000 + i));
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_busy_toggle", Busy, (i % 2 == 0) ? 1 : 0);
        end
        drain(20);
        chk("t4_no_read_enable", cnt_re, 0);
        chk("t4_gnt1_count", cnt_g1, 3);

        // 5: reset during the response cycle of a port-1 read
        cnt_rv1 = 0;
        q1.push_back(mk(0, 3, 0));
        k = 0;
        while (!Gnt1 && k < 10) begin tick(); k++; end
        chk("t5_gnt1_seen", Gnt1, 1);
        tick();
        do_reset(1);
        for (int i = 0; i < 3; i++) tick();
        chk("t5_no_rvalid1", cnt_rv1, 0);
        chk("t5_rdata1_zero", RData1, 0);
        chk("t5_idle", Busy, 0);
        glog.delete();
        q0.push_back(mk(0, 8, 0));
        q1.push_back(mk(0, 9, 0));
        drain(30);
        chk("t5_first_grant_port0", (glog.size() > 0) ? glog[0] : 9, 0);

        // 6: random traffic on a small address window
        for (int i = 0; i < 300; i++) begin
            if (q0.size() < 2 && $urandom_range(0, 2) == 0)
                q0.push_back(mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom));
            if (q1.size() < 2 && $urandom_range(0, 2) == 0)
                q1.push_back(mk($urandom_range(0, 1), $urandom_range(0, 3), $urandom));
            tick();
        end
        drain(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
